// File: rtl/packet_source_gen_pkg.sv
// Shared constants for the synthetic packet source: FSM encodings, flit field offsets
// and the LFSR next-state function reused by every source instance.
package packet_source_gen_pkg;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_WAIT_ACK = 2'd1;
    localparam logic [1:0] ST_DONE     = 2'd2;

    // Flag bits are counted down from the flit MSB; length sits just above dest.
    localparam int HEAD_FROM_MSB = 1;
    localparam int TAIL_FROM_MSB = 2;
    localparam int LEN_W         = 8;

    // Galois form of x^16+x^14+x^13+x^11+1, shifting right.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr16_next(input logic [15:0] s);
        lfsr16_next = s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/packet_source_gen_lfsr16.sv
// Free-running 16-bit Galois LFSR, one step per clock; reloads SEED on reset.
// No flow control: the value is consumed (or not) by the owner every cycle.
module packet_source_gen_lfsr16
    import packet_source_gen_pkg::*;
#(
    parameter logic [15:0] SEED = 16'd1
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] out
);

    logic [15:0] lfsr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) lfsr_q <= SEED;
        else       lfsr_q <= lfsr16_next(lfsr_q);
    end

    assign out = lfsr_q;

endmodule

// File: rtl/packet_source_gen.sv
// Synthetic NoC packet source: head leaves one edge after the inject decision, next flit on the ack edge.
// Two-phase req/ack: each flit is held until its ack toggle; enable only gates new packet starts.
module packet_source_gen
    import packet_source_gen_pkg::*;
#(
    parameter int          ID          = 0,
    parameter int          SIZE        = 16,
    parameter int          FLITS_MIN   = 1,
    parameter int          FLITS_MAX   = 8,
    parameter int          PACKETS     = 2,
    parameter int          DEST_COUNT  = 4,
    parameter int          DEST_BITS   = 2,
    parameter int          MODE        = 0,
    parameter int          SOURCE_RATE = 1024,
    parameter int          PERIOD      = 16,
    parameter logic [15:0] SEED        = 16'd1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    output logic            req,
    input  logic            ack,
    output logic [SIZE-1:0] data,
    output logic            busy,
    output logic [15:0]     pkt_count,
    output logic            done
);

    localparam int PCW      = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int LEN_SPAN = FLITS_MAX - FLITS_MIN + 1;

    logic [15:0]          lfsr;
    logic [1:0]           state_q, state_d;
    logic                 req_q, req_d, busy_q, busy_d, done_q, done_d, ack_old_q;
    logic [SIZE-1:0]      data_q, data_d;
    logic [15:0]          cnt_q, cnt_d;
    logic [LEN_W-1:0]     left_q, left_d;
    logic [PCW-1:0]       pcnt_q;
    logic                 ack_rcv, inject;
    logic [LEN_W-1:0]     len;
    logic [7:0]           dest_raw;
    logic [DEST_BITS-1:0] dest;
    logic [SIZE-3:0]      payload;
    logic [16:0]          cnt_inc;

    packet_source_gen_lfsr16 #(.SEED(SEED)) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .out   (lfsr)
    );

    assign ack_rcv  = ack ^ ack_old_q;
    assign inject   = (MODE == 1) ? (pcnt_q == PCW'(PERIOD - 1))
                                  : (int'(lfsr[9:0]) < SOURCE_RATE);
    assign len      = LEN_W'(FLITS_MIN + int'(lfsr[15:8]) % LEN_SPAN);
    assign dest_raw = 8'(int'(lfsr[7:0]) % DEST_COUNT);
    // A source never addresses itself: its own id is remapped to the next node.
    assign dest     = (dest_raw == 8'(ID)) ? DEST_BITS'((ID + 1) % DEST_COUNT)
                                           : DEST_BITS'(dest_raw);
    assign payload  = (SIZE - 2)'(lfsr);
    assign cnt_inc  = {1'b0, cnt_q} + 17'd1;

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        data_d  = data_q;
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        left_d  = left_q;
        done_d  = done_q;
        case (state_q)
            ST_IDLE: begin
                if (!done_q && enable && inject) begin
                    data_d                              = '0;
                    data_d[SIZE-HEAD_FROM_MSB]          = 1'b1;
                    data_d[SIZE-TAIL_FROM_MSB]          = (len == LEN_W'(1));
                    data_d[DEST_BITS-1:0]               = dest;
                    data_d[DEST_BITS+LEN_W-1:DEST_BITS] = len;
                    req_d   = ~req_q;
                    busy_d  = 1'b1;
                    left_d  = len - LEN_W'(1);
                    state_d = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                if (ack_rcv) begin
                    if (left_q != '0) begin
                        data_d = {1'b0, (left_q == LEN_W'(1)), payload};
                        req_d  = ~req_q;
                        left_d = left_q - LEN_W'(1);
                    end else begin
                        busy_d = 1'b0;
                        if (cnt_q != 16'hFFFF) cnt_d = cnt_inc[15:0];
                        if (cnt_inc == 17'(PACKETS)) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
            end
            ST_DONE: done_d = 1'b1;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            req_q     <= 1'b0;
            data_q    <= '0;
            busy_q    <= 1'b0;
            cnt_q     <= '0;
            left_q    <= '0;
            done_q    <= (PACKETS == 0);
            ack_old_q <= 1'b0;
            pcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            data_q    <= data_d;
            busy_q    <= busy_d;
            cnt_q     <= cnt_d;
            left_q    <= left_d;
            done_q    <= done_d;
            ack_old_q <= ack;
            pcnt_q    <= (pcnt_q == PCW'(PERIOD - 1)) ? '0 : pcnt_q + 1'b1;
        end
    end

    assign req       = req_q;
    assign data      = data_q;
    assign busy      = busy_q;
    assign pkt_count = cnt_q;
    assign done      = done_q;

endmodule

// File: tb/tb_packet_source_gen.sv
// Directed bench: four differently parameterised sources, exercised one at a time against
// a cycle-level reference model with a flit scoreboard.
module tb_packet_source_gen;

    localparam int N      = 4;
    localparam int ID_T   [N] = '{0, 1, 2, 0};
    localparam int FMIN_T [N] = '{4, 1, 1, 1};
    localparam int FMAX_T [N] = '{4, 1, 8, 8};
    localparam int PKT_T  [N] = '{2, 5, 300, 0};
    localparam int MODE_T [N] = '{0, 1, 0, 0};
    localparam int RATE_T [N] = '{1024, 1024, 512, 1024};
    localparam int SEED_T [N] = '{1, 16'h1D0F, 16'hACE1, 7};
    localparam int PER_T      = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0] rst, en, ack;
    wire  [N-1:0] req, busy, done;
    wire  [15:0]  data [N];
    wire  [15:0]  cnt  [N];

    for (genvar g = 0; g < N; g++) begin : g_dut
        packet_source_gen #(
            .ID(ID_T[g]), .SIZE(16), .FLITS_MIN(FMIN_T[g]), .FLITS_MAX(FMAX_T[g]),
            .PACKETS(PKT_T[g]), .DEST_COUNT(4), .DEST_BITS(2), .MODE(MODE_T[g]),
            .SOURCE_RATE(RATE_T[g]), .PERIOD(PER_T), .SEED(16'(SEED_T[g]))
        ) u_dut (
            .clk(clk), .reset(rst[g]), .enable(en[g]), .req(req[g]), .ack(ack[g]),
            .data(data[g]), .busy(busy[g]), .pkt_count(cnt[g]), .done(done[g])
        );
    end

    int vecs = 0;
    int fails = 0;
    int cur, cyc, toggles, heads, first_head, last_head, fl_in_pkt, hdr_len;
    int m_st, m_left, m_cnt, m_pcnt, m_len;
    logic [15:0] m_lfsr, last_data, hold_data;
    logic        m_req, m_busy, m_done, obs_req;
    logic [15:0] sb [$];
    logic [15:0] flits_log [$];

    function automatic logic [15:0] ref_lfsr(input logic [15:0] s);
        logic [15:0] t;
        t = {1'b0, s[15:1]};
        if (s[0]) t = t ^ 16'hB400;
        return t;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start(input int i);
        cur = i;
        rst[i] = 1'b1; en[i] = 1'b1; ack[i] = 1'b0;
        @(negedge clk);
        chk("rst_req", req[i], 0);
        chk("rst_data", data[i], 0);
        chk("rst_busy", busy[i], 0);
        chk("rst_cnt", cnt[i], 0);
        chk("rst_done", done[i], PKT_T[i] == 0);
        rst[i] = 1'b0;
        m_lfsr = 16'(SEED_T[i]); m_st = 0; m_pcnt = 0; m_cnt = 0; m_left = 0;
        m_req = 1'b0; m_busy = 1'b0; m_done = (PKT_T[i] == 0);
        sb.delete(); flits_log.delete();
        obs_req = 1'b0; last_data = '0;
        toggles = 0; heads = 0; fl_in_pkt = 0; hdr_len = 0; cyc = 0;
        first_head = -1; last_head = 0;
    endtask

    task automatic observe_flit();
        logic [15:0] d;
        d = data[cur];
        toggles++;
        chk("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) chk("flit_data", d, sb.pop_front());
        flits_log.push_back(d);
        if (d[15]) begin
            hdr_len = int'(d[9:2]);
            chk("len_range", (hdr_len >= FMIN_T[cur]) && (hdr_len <= FMAX_T[cur]), 1);
            chk("dest_not_self", int'(d[1:0]) != ID_T[cur], 1);
            if (MODE_T[cur] == 1 && heads > 0) chk("head_gap", cyc - last_head, PER_T);
            if (heads == 0) first_head = cyc;
            last_head = cyc;
            heads++;
            fl_in_pkt = 0;
        end
        fl_in_pkt++;
        if (d[14]) chk("len_vs_flits", fl_in_pkt, hdr_len);
    endtask

    // mode: 0 = ack any outstanding flit, 1 = withhold ack, 2 = toggle ack unconditionally
    task automatic step(input int mode);
        logic        ackr, inj;
        logic [15:0] f;
        int          d;
        ackr = (mode == 2) || (mode == 0 && req[cur] != ack[cur]);
        if (ackr) ack[cur] = ~ack[cur];
        case (m_st)
            0: begin
                inj = (MODE_T[cur] == 1) ? (m_pcnt == PER_T - 1)
                                         : (int'(m_lfsr[9:0]) < RATE_T[cur]);
                if (!m_done && en[cur] && inj) begin
                    m_len = FMIN_T[cur] + int'(m_lfsr[15:8]) % (FMAX_T[cur] - FMIN_T[cur] + 1);
                    d = int'(m_lfsr[7:0]) % 4;
                    if (d == ID_T[cur]) d = (d + 1) % 4;
                    f = 16'h8000 | ((m_len == 1) ? 16'h4000 : 16'h0000) | 16'(m_len << 2) | 16'(d);
                    sb.push_back(f);
                    m_left = m_len - 1; m_busy = 1'b1; m_req = ~m_req; m_st = 1;
                end
            end
            1: if (ackr) begin
                if (m_left > 0) begin
                    f = {2'b00, m_lfsr[13:0]};
                    if (m_left == 1) f[14] = 1'b1;
                    sb.push_back(f);
                    m_left--; m_req = ~m_req;
                end else begin
                    m_busy = 1'b0; m_cnt++;
                    if (m_cnt == PKT_T[cur]) begin m_st = 2; m_done = 1'b1; end
                    else m_st = 0;
                end
            end
            default: ;
        endcase
        m_pcnt = (m_pcnt == PER_T - 1) ? 0 : m_pcnt + 1;
        m_lfsr = ref_lfsr(m_lfsr);
        @(negedge clk);
        cyc++;
        chk("req", req[cur], m_req);
        chk("busy", busy[cur], m_busy);
        chk("pkt_count", cnt[cur], m_cnt);
        chk("done", done[cur], m_done);
        if (req[cur] != obs_req) begin
            obs_req = req[cur];
            observe_flit();
            last_data = data[cur];
        end else begin
            chk("data_stable", data[cur], last_data);
        end
    endtask

    initial begin
        int h;
        rst = '1; en = '0; ack = '0;

        // Fixed 4-flit packets, ack held for 20 cycles on flit 1
        start(0);
        for (int k = 0; k < 50 && toggles < 2; k++) step(0);
        chk("t2_reach_flit1", toggles, 2);
        hold_data = data[0];
        for (int k = 0; k < 20; k++) begin
            step(1);
            chk("t2_hold_data", data[0], hold_data);
        end
        for (int k = 0; k < 80 && m_st != 2; k++) step(0);
        chk("t1_reach_done", m_st, 2);
        chk("t1_toggles", toggles, 8);
        chk("t1_done", done[0], 1);
        chk("t1_cnt", cnt[0], 2);
        chk("t1_nflits", flits_log.size(), 8);
        foreach (flits_log[j]) begin
            chk("t1_head_bit", flits_log[j][15], (j % 4) == 0);
            chk("t1_tail_bit", flits_log[j][14], (j % 4) == 3);
        end
        step(2); step(0); step(0);
        chk("t6_ack_in_done", toggles, 8);
        rst[0] = 1'b1;

        // Periodic injection, single-flit packets
        start(1);
        for (int k = 0; k < 200 && m_st != 2; k++) step(0);
        chk("t3_reach_done", m_st, 2);
        chk("t3_heads", heads, 5);
        chk("t3_first_head", first_head, PER_T);
        foreach (flits_log[j]) chk("t3_head_tail", flits_log[j][15:14], 2'b11);
        rst[1] = 1'b1;

        // Random lengths and destinations, enable drop, reset mid-packet
        start(2);
        for (int k = 0; k < 2000 && m_cnt < 5; k++) step(0);
        for (int k = 0; k < 400 && !(m_st == 1 && m_left > 0); k++) step(0);
        chk("t5_mid_packet", busy[2], 1);
        en[2] = 1'b0;
        for (int k = 0; k < 50 && m_st == 1; k++) step(0);
        chk("t5_pkt_completed", busy[2], 0);
        h = heads;
        for (int k = 0; k < 30; k++) step(0);
        chk("t5_no_head_disabled", heads, h);
        en[2] = 1'b1;
        for (int k = 0; k < 4000 && m_cnt < 200; k++) step(0);
        chk("t4_packets", cnt[2], 200);
        for (int k = 0; k < 100 && !(m_busy && m_req); k++) step(0);
        chk("t5_busy_before_rst", {busy[2], req[2]}, 2'b11);
        #2 rst[2] = 1'b1;
        #1;
        chk("t5_rst_req", req[2], 0);
        chk("t5_rst_data", data[2], 0);
        chk("t5_rst_busy", busy[2], 0);
        chk("t5_rst_cnt", cnt[2], 0);

        // No packets at all: done from reset, acks ignored
        start(3);
        for (int k = 0; k < 1000; k++) step((k % 50 == 10) ? 2 : 0);
        chk("t6_no_toggles", toggles, 0);
        chk("t6_done", done[3], 1);
        rst[3] = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

endmodule
